// File: rtl/lfsr_word_sampler.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_word_sampler
// Description : Packs the serial randomBit stream into WIDTH-bit words and
//               uses rejection sampling so that delivered values are uniform
//               over [0, LIMIT). Accepted words leave over a valid/ready
//               handshake. Rejected words are counted in a saturating counter.
//
// Ports       : clk          - rising-edge clock
//               rstn         - synchronous active-low reset
//               randomBit    - serial random bit, one per clock
//               out_data     - accepted word, frozen while out_valid = 1
//               out_valid    - an accepted word is waiting
//               out_ready    - consumer takes the word (only used in HOLD)
//               reject_count - number of rejected words, saturating
//
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_word_sampler #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 200,
    parameter int REJ_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             randomBit,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REJ_W-1:0] reject_count
);

    // The bit counter only has to reach WIDTH-1, so log2(WIDTH) bits suffice.
    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    // LIMIT may equal 2^WIDTH, so the bound is held one bit wider than sr.
    localparam logic [WIDTH:0]     c_LIMIT = (WIDTH + 1)'(LIMIT);
    localparam logic [REJ_W-1:0]   c_REJ_MAX = {REJ_W{1'b1}};

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_EVAL    = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sr;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic [REJ_W-1:0]   r_rej;

    logic               w_accept;

    assign w_accept = ({1'b0, r_sr} < c_LIMIT);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_COLLECT;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_rej   <= '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    // First sampled bit ends up in the MSB.
                    r_sr <= {r_sr[WIDTH-2:0], randomBit};
                    if (r_cnt == c_LAST) begin
                        // Cleared here rather than on leaving EVAL/HOLD so the
                        // counter never has to represent WIDTH itself.
                        r_cnt   <= '0;
                        r_state <= S_EVAL;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                S_EVAL: begin
                    if (w_accept) begin
                        r_data  <= r_sr;
                        r_valid <= 1'b1;
                        r_state <= S_HOLD;
                    end else begin
                        if (r_rej != c_REJ_MAX) begin
                            r_rej <= r_rej + REJ_W'(1);
                        end
                        r_state <= S_COLLECT;
                    end
                end

                S_HOLD: begin
                    // The bit present on the transfer edge is dropped.
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_COLLECT;
                    end
                end

                default: begin
                    r_state <= S_COLLECT;
                    r_cnt   <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_data     = r_data;
    assign out_valid    = r_valid;
    assign reject_count = r_rej;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_word_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_word_sampler
// Description : Drives three sampler instances (LIMIT=200/REJ_W=16,
//               LIMIT=200/REJ_W=4, LIMIT=256/REJ_W=16) from one shared bit
//               stream. A word-level reference model pushes expected words
//               into per-instance queues; a monitor pops them when out_valid
//               rises and also compares the handshake and counter each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_word_sampler;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rstn;
    logic randomBit;
    logic out_ready;

    logic [7:0]  d0, d1, d2;
    logic        v0, v1, v2;
    logic [15:0] rc0, rc2;
    logic [3:0]  rc1;

    always #5 clk = ~clk;

    lfsr_word_sampler #(.WIDTH(8), .LIMIT(200), .REJ_W(16)) u0 (
        .clk(clk), .rstn(rstn), .randomBit(randomBit), .out_data(d0),
        .out_valid(v0), .out_ready(out_ready), .reject_count(rc0));

    lfsr_word_sampler #(.WIDTH(8), .LIMIT(200), .REJ_W(4)) u1 (
        .clk(clk), .rstn(rstn), .randomBit(randomBit), .out_data(d1),
        .out_valid(v1), .out_ready(out_ready), .reject_count(rc1));

    lfsr_word_sampler #(.WIDTH(8), .LIMIT(256), .REJ_W(16)) u2 (
        .clk(clk), .rstn(rstn), .randomBit(randomBit), .out_data(d2),
        .out_valid(v2), .out_ready(out_ready), .reject_count(rc2));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: a word is WIDTH consecutive sampled bits, followed
    // by one evaluation edge; an accepted word is held until taken.
    // ------------------------------------------------------------------
    typedef struct {
        int v;
        int e;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int lim  [3] = '{200, 200, 256};
    int rmax [3] = '{65535, 15, 65535};
    int m_nbits [3];
    int m_acc   [3];
    bit m_hold  [3];
    int m_data  [3];
    int m_rej   [3];
    int m_deliv [3];
    bit m_prev  [3];
    int edge_n = 0;

    task automatic push_exp(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic model_step(input int i);
        exp_t e;
        if (!rstn) begin
            m_nbits[i] = 0; m_acc[i] = 0; m_hold[i] = 0;
            m_data[i]  = 0; m_rej[i] = 0;
        end else if (m_hold[i]) begin
            if (out_ready) begin
                m_hold[i] = 0;
                m_deliv[i]++;
            end
        end else if (m_nbits[i] == W) begin
            if (m_acc[i] < lim[i]) begin
                m_hold[i] = 1;
                m_data[i] = m_acc[i];
                e.v = m_acc[i];
                e.e = edge_n;
                push_exp(i, e);
            end else if (m_rej[i] < rmax[i]) begin
                m_rej[i]++;
            end
            m_nbits[i] = 0;
            m_acc[i]   = 0;
        end else begin
            m_acc[i] = m_acc[i] * 2 + int'(randomBit);
            m_nbits[i]++;
        end
    endtask

    always @(posedge clk) begin
        edge_n++;
        for (int i = 0; i < 3; i++) model_step(i);
    end

    task automatic mon(input int i, input logic v, input int d, input int rc);
        exp_t e;
        bit   got;
        chk($sformatf("u%0d.out_valid", i), int'(v), int'(m_hold[i]));
        chk($sformatf("u%0d.out_data", i), d, m_data[i]);
        chk($sformatf("u%0d.reject_count", i), rc, m_rej[i]);
        if (v && !m_prev[i]) begin
            got = 1'b0;
            case (i)
                0:       if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                1:       if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
            endcase
            if (!got) begin
                chk($sformatf("u%0d.unexpected_word", i), 1, 0);
            end else begin
                chk($sformatf("u%0d.word", i), d, e.v);
                chk($sformatf("u%0d.word_edge", i), edge_n, e.e);
            end
            if (i != 2) chk($sformatf("u%0d.below_limit", i), int'(d < 200), 1);
        end
        m_prev[i] = v;
    endtask

    always @(posedge clk) begin
        #1;
        mon(0, v0, int'(d0), int'(rc0));
        mon(1, v1, int'(d1), int'(rc1));
        mon(2, v2, int'(d2), int'(rc2));
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc(input logic b, input logic r);
        randomBit = b;
        out_ready = r;
        @(posedge clk);
        #2;
    endtask

    // Eight bits MSB first, then the evaluation edge.
    task automatic send_word(input logic [7:0] w, input logic r);
        for (int k = 7; k >= 0; k--) cyc(w[k], r);
        cyc(1'b0, r);
    endtask

    initial begin
        int cycles;
        rstn = 1'b0; randomBit = 1'b0; out_ready = 1'b1;
        repeat (3) cyc(1'b0, 1'b1);
        chk("reset.valid", int'(v0), 0);
        chk("reset.data", int'(d0), 0);
        chk("reset.rej", int'(rc0), 0);
        rstn = 1'b1;

        // 0xA5 accepted after edge 8, taken on edge 9
        send_word(8'hA5, 1'b1);
        chk("a5.valid", int'(v0), 1);
        chk("a5.data", int'(d0), 8'hA5);
        chk("a5.rej", int'(rc0), 0);
        cyc(1'b0, 1'b1);
        chk("a5.valid_drop", int'(v0), 0);
        chk("a5.data_kept", int'(d0), 8'hA5);

        // 0xFF rejected at LIMIT=200, accepted at LIMIT=256; then 0x12
        send_word(8'hFF, 1'b1);
        chk("ff.valid", int'(v0), 0);
        chk("ff.rej", int'(rc0), 1);
        chk("ff256.valid", int'(v2), 1);
        chk("ff256.data", int'(d2), 8'hFF);
        chk("ff256.rej", int'(rc2), 0);
        send_word(8'h12, 1'b1);
        chk("x12.valid", int'(v0), 1);
        chk("x12.data", int'(d0), 8'h12);
        cyc(1'b0, 1'b1);

        // Backpressure on 0x3C
        send_word(8'h3C, 1'b0);
        chk("bp.valid", int'(v0), 1);
        repeat (20) begin
            cyc(1'($urandom_range(0, 1)), 1'b0);
            chk("bp.hold_valid", int'(v0), 1);
            chk("bp.hold_data", int'(d0), 8'h3C);
        end
        cyc(1'($urandom_range(0, 1)), 1'b1);
        chk("bp.valid_drop", int'(v0), 0);
        send_word(8'h5A, 1'b1);
        chk("bp.next_word", int'(d0), 8'h5A);
        cyc(1'b0, 1'b1);

        // Reset after four bits of a word
        repeat (4) cyc(1'b1, 1'b1);
        rstn = 1'b0;
        cyc(1'b1, 1'b1);
        chk("rst_mid.valid", int'(v0), 0);
        chk("rst_mid.data", int'(d0), 0);
        chk("rst_mid.rej", int'(rc0), 0);
        rstn = 1'b1;
        send_word(8'h21, 1'b1);
        chk("rst_mid.first_word", int'(d0), 8'h21);
        cyc(1'b0, 1'b1);

        // Reset while holding
        send_word(8'h33, 1'b0);
        chk("rst_hold.pre_valid", int'(v0), 1);
        rstn = 1'b0;
        cyc(1'b0, 1'b0);
        chk("rst_hold.valid", int'(v0), 0);
        chk("rst_hold.data", int'(d0), 0);
        rstn = 1'b1;

        // Saturating counter on the REJ_W=4 instance
        repeat (20) send_word(8'hFF, 1'b1);
        chk("sat.rej4", int'(rc1), 15);
        chk("sat.rej16", int'(rc0), 20);
        chk("sat.valid4", int'(v1), 0);

        // Random soak
        cycles = 0;
        while (m_deliv[0] < 1000 && cycles < 40000) begin
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            cycles++;
        end
        chk("soak.words_delivered", int'(m_deliv[0] >= 1000), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_word_sampler.md
# lfsr_word_sampler

Consumes the single-bit `randomBit` stream from the LFSR stage, one bit per clock, and assembles it into WIDTH-bit words. Words at or above LIMIT are rejected, so accepted values are uniform over [0, LIMIT). Accepted words go to game or display logic over a valid/ready handshake. Consumed and discarded bits are never reused.

## Interface
Parameters:
- `WIDTH`, 8: word width in bits; legal range 2..16.
- `LIMIT`, 200: exclusive upper bound on delivered values; legal range 1..2^WIDTH. When LIMIT = 2^WIDTH, no word is rejected.
- `REJ_W`, 16: width of the saturating reject counter.

Ports:
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: reset is synchronous and active-low.
- `randomBit` input 1: serial random bit from the LFSR; a new bit is presented every clock.
- `out_data` output WIDTH: accepted random value. Stable while `out_valid` = 1.
- `out_valid` output 1: an accepted word is available.
- `out_ready` input 1: the consumer accepts the word.
- `reject_count` output REJ_W: number of rejected words; saturates at 2^REJ_W−1.

## Operation
- Reset (`rstn` = 0 at a rising edge):
  - state goes to COLLECT, bit count to 0, shift register to 0.
  - `out_data` = 0, `out_valid` = 0, `reject_count` = 0.
- Reset applied mid-word or in HOLD discards the partial or pending word. No `out_valid` pulse is produced.
- State machine:
  - COLLECT: on each edge, shift `sr <= {sr[WIDTH-2:0], randomBit}` and increment the count.
    - On the edge that captures bit number WIDTH−1 (counting from 0), go to EVAL.
    - The first sampled bit ends up in the MSB.
  - EVAL (1 cycle): `randomBit` is ignored.
    - If `sr` < LIMIT: `out_data <= sr`, `out_valid <= 1`, go to HOLD.
    - Otherwise: `reject_count` increments (held at max when saturated), count resets to 0, go to COLLECT.
  - HOLD: `out_valid` = 1 and `out_data` is frozen. `randomBit` is ignored.
    - On an edge with `out_ready` = 1: `out_valid <= 0`, count resets to 0, go to COLLECT.
- The comparison is an unsigned comparison of WIDTH-bit `sr` against LIMIT, evaluated at WIDTH+1 bits so that LIMIT = 2^WIDTH fits.
- `out_ready` is ignored outside HOLD. Asserting it early has no effect.
- `out_data` keeps its last accepted value after a transfer, until the next acceptance.

## Timing
- Edge numbering: edge 0 is the first rising edge with `rstn` = 1.
  - Edges 0..WIDTH−1 sample bits.
  - Edge WIDTH is EVAL.
  - If the word is accepted, `out_valid` is high after edge WIDTH.
- Transfer happens on an edge where `out_valid` = 1 and `out_ready` = 1.
  - The `randomBit` present at the transfer edge is discarded.
  - The next word samples on the following WIDTH edges.
  - `out_valid` can rise again WIDTH+1 edges after the transfer edge.
- Peak throughput, with `out_ready` held at 1: one word per WIDTH+2 cycles.
- Rejection costs WIDTH+1 cycles per rejected word. `reject_count` updates on the EVAL edge.
- There is no combinational path from any input to any output; all outputs are registered.

## Test plan
- WIDTH=8, LIMIT=200, `out_ready`=1. Drive bits 1,0,1,0,0,1,0,1 after reset → `out_valid` high after edge 8 for exactly 1 cycle, `out_data` = 0xA5, `reject_count` = 0.
- Drive 8 ones, then 0,0,0,1,0,0,1,0 → no valid for the first word; `reject_count` = 1 after edge 8; second word gives `out_data` = 0x12 with valid after edge 17.
- Backpressure: accept 0x3C with `out_ready`=0 for 20 cycles while driving random bits → `out_valid` stays 1 and `out_data` stays 0x3C throughout. Then raise `out_ready` for 1 cycle → valid drops; the next 8 bits after the transfer edge form the next word.
- Reset mid-operation: pull `rstn` low after 4 bits of a word, and separately while in HOLD → outputs return to 0. After release, the first word is built only from bits sampled after release.
- REJ_W=4: feed 20 consecutive all-ones words → `reject_count` counts to 15 and stays at 15, with no `out_valid`.
- LIMIT=256, WIDTH=8: feed 0xFF → accepted, `out_data` = 0xFF, `reject_count` = 0. Scoreboard 1000 LFSR-fed words with LIMIT=200 → every delivered value < 200.
